// File: rtl/rv32i_pkg.sv
// Shared constants and the pipeline stage-tag type used by the pipe_ctrl slice.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              RegWrite;
    logic              MemRead;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int XLEN   = rv32i_pkg::XLEN,
  parameter int REG_AW = rv32i_pkg::REG_AW
);

  logic              id_valid, id_RegWrite, id_MemRead;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              flush;
  logic [XLEN-1:0]   ex_result, mem_rdata;

  logic              stall;
  logic [REG_AW-1:0] IDEXrs1, IDEXrs2, IDEXrd;
  logic              IDEX_RegWrite, IDEX_MemRead;
  logic [REG_AW-1:0] EXMEMrd;
  logic              EXMEM_RegWrite;
  logic [XLEN-1:0]   EXMEM_result;
  logic [REG_AW-1:0] MEMWBrd;
  logic              MEMWB_RegWrite;
  logic [XLEN-1:0]   MEMWB_data;

  modport master (
    output id_valid, id_RegWrite, id_MemRead, id_rs1, id_rs2, id_rd,
           flush, ex_result, mem_rdata,
    input  stall, IDEXrs1, IDEXrs2, IDEXrd, IDEX_RegWrite, IDEX_MemRead,
           EXMEMrd, EXMEM_RegWrite, EXMEM_result,
           MEMWBrd, MEMWB_RegWrite, MEMWB_data
  );

  modport slave (
    input  id_valid, id_RegWrite, id_MemRead, id_rs1, id_rs2, id_rd,
           flush, ex_result, mem_rdata,
    output stall, IDEXrs1, IDEXrs2, IDEXrd, IDEX_RegWrite, IDEX_MemRead,
           EXMEMrd, EXMEM_RegWrite, EXMEM_result,
           MEMWBrd, MEMWB_RegWrite, MEMWB_data
  );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// Combinational load-use hazard detector; a resolving flush suppresses the stall.
module load_use_detect #(
  parameter int REG_AW = rv32i_pkg::REG_AW
) (
  input  logic              id_valid_i,
  input  logic              idex_mem_read_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              flush_i,
  output logic              stall_o
);

  // x0 is never a real producer, so a load into x0 cannot create a hazard.
  assign stall_o = id_valid_i && idex_mem_read_i && (idex_rd_i != '0) &&
                   ((idex_rd_i == id_rs1_i) || (idex_rd_i == id_rs2_i)) &&
                   !flush_i;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register control for ID/EX, EX/MEM and MEM/WB with load-use stalling.
// Optional STALL_COUNTER_EN adds a saturating 16-bit stall_count output.
module pipe_ctrl #(
  parameter int XLEN   = rv32i_pkg::XLEN,
  parameter int REG_AW = rv32i_pkg::REG_AW
) (
  input  logic        clk,
  input  logic        reset,
`ifdef STALL_COUNTER_EN
  output logic [15:0] stall_count,
`endif
  pipe_ctrl_if.slave  bus
);

  import rv32i_pkg::*;

  stage_tag_t        idex_q, idex_d;
  logic [REG_AW-1:0] idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
  stage_tag_t        exmem_q;
  logic [XLEN-1:0]   exmem_result_q;
  logic [REG_AW-1:0] memwb_rd_q;
  logic              memwb_rw_q;
  logic [XLEN-1:0]   memwb_data_q, memwb_data_d;
  logic              stall;

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .id_valid_i      (bus.id_valid),
    .idex_mem_read_i (idex_q.MemRead),
    .idex_rd_i       (idex_q.rd),
    .id_rs1_i        (bus.id_rs1),
    .id_rs2_i        (bus.id_rs2),
    .flush_i         (bus.flush),
    .stall_o         (stall)
  );

  // NOTE: every branch of a combinational block must assign each output, so
  // defaults go first; otherwise synthesis infers a latch.
  always_comb begin
    idex_d     = BUBBLE;
    idex_rs1_d = '0;
    idex_rs2_d = '0;
    if (bus.id_valid && !stall && !bus.flush) begin
      idex_d.rd       = bus.id_rd;
      idex_d.RegWrite = bus.id_RegWrite && (bus.id_rd != '0);
      idex_d.MemRead  = bus.id_MemRead;
      idex_rs1_d      = bus.id_rs1;
      idex_rs2_d      = bus.id_rs2;
    end
  end

  assign memwb_data_d = exmem_q.MemRead ? bus.mem_rdata : exmem_result_q;

  // NOTE: registers use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q         <= BUBBLE;
      idex_rs1_q     <= '0;
      idex_rs2_q     <= '0;
      exmem_q        <= BUBBLE;
      exmem_result_q <= '0;
      memwb_rd_q     <= '0;
      memwb_rw_q     <= 1'b0;
      memwb_data_q   <= '0;
    end else begin
      idex_q         <= idex_d;
      idex_rs1_q     <= idex_rs1_d;
      idex_rs2_q     <= idex_rs2_d;
      exmem_q        <= idex_q;
      exmem_result_q <= bus.ex_result;
      memwb_rd_q     <= exmem_q.rd;
      memwb_rw_q     <= exmem_q.RegWrite;
      memwb_data_q   <= memwb_data_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count_q, stall_count_d;

  assign stall_count_d = (stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1
                                                                : stall_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

  assign bus.stall          = stall;
  assign bus.IDEXrs1        = idex_rs1_q;
  assign bus.IDEXrs2        = idex_rs2_q;
  assign bus.IDEXrd         = idex_q.rd;
  assign bus.IDEX_RegWrite  = idex_q.RegWrite;
  assign bus.IDEX_MemRead   = idex_q.MemRead;
  assign bus.EXMEMrd        = exmem_q.rd;
  assign bus.EXMEM_RegWrite = exmem_q.RegWrite;
  assign bus.EXMEM_result   = exmem_result_q;
  assign bus.MEMWBrd        = memwb_rd_q;
  assign bus.MEMWB_RegWrite = memwb_rw_q;
  assign bus.MEMWB_data     = memwb_data_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_valid, id_RegWrite, id_MemRead  in  1 each  decoded instruction in ID.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  in  REG_AW each  ID register addresses.
REQ-007 SHALL have port flush  in  1  taken branch/jump resolved in EX.
REQ-008 SHALL have ports ex_result, mem_rdata  in  XLEN each  ALU output and data-memory read data.
REQ-009 SHALL have port stall  out  1  hold PC and IF/ID.
REQ-010 SHALL have ports IDEXrs1, IDEXrs2, IDEXrd  out  REG_AW each  ID/EX tags, read by the forwarding unit.
REQ-011 SHALL have ports IDEX_RegWrite, IDEX_MemRead  out  1 each  ID/EX control.
REQ-012 SHALL have ports EXMEMrd  out  REG_AW, EXMEM_RegWrite  out  1, EXMEM_result  out  XLEN  EX/MEM stage.
REQ-013 SHALL have ports MEMWBrd  out  REG_AW, MEMWB_RegWrite  out  1, MEMWB_data  out  XLEN  MEM/WB stage, also the register-bank write port.

Function
REQ-014 stall SHALL be combinational: 1 iff id_valid & IDEX_MemRead & IDEXrd!=0 & (IDEXrd==id_rs1 | IDEXrd==id_rs2) & !flush.
REQ-015 With no stall and no flush, ID/EX SHALL capture id_* on each edge; id_valid=0 captures a bubble.
REQ-016 On stall or flush, ID/EX SHALL capture a bubble: rs1=rs2=rd=0, RegWrite=0, MemRead=0.
REQ-017 ID/EX capture SHALL force IDEX_RegWrite=0 when id_rd==0, so x0 writes are never issued.
REQ-018 EX/MEM and MEM/WB SHALL advance every cycle regardless of stall or flush.
REQ-019 EX/MEM SHALL capture IDEXrd, IDEX_RegWrite, IDEX_MemRead (internal) and ex_result.
REQ-020 MEM/WB SHALL capture EXMEMrd and EXMEM_RegWrite, and MEMWB_data = mem_rdata if the EX/MEM load flag is set, else EXMEM_result.
REQ-021 Latency: an instruction in ID at edge N SHALL appear in ID/EX after N+1, EX/MEM after N+2 and MEM/WB after N+3.
REQ-022 flush and stall in the same cycle: flush SHALL win; stall=0 and a single bubble is inserted.
REQ-023 A load followed by a dependent instruction SHALL stall exactly one cycle; the instruction then issues with the load in EX/MEM.

Reset
REQ-024 While reset=1, all stage registers and outputs SHALL be 0, i.e. bubbles; stall SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight instructions immediately; the first ID capture occurs on the first edge after deassertion.

Configuration
REQ-026 With STALL_COUNTER_EN defined, output stall_count (16 bits) SHALL count cycles with stall=1, saturate at 16'hFFFF and reset to 0.
REQ-027 Without STALL_COUNTER_EN, the stall_count port and its logic SHALL be absent.

Structure
REQ-028 Package rv32i_pkg SHALL hold the XLEN and REG_AW constants, the stage-tag typedef {rd, RegWrite, MemRead} and the BUBBLE tag constant.
REQ-029 Sub-module load_use_detect SHALL implement REQ-014 combinationally; pipe_ctrl holds all registers.

Verification
REQ-030 Reset held 2 cycles -> all outputs 0, stall 0; the first ID/EX capture occurs 1 edge after release.
REQ-031 ADD x3,x1,x2 (rd=3, RegWrite=1) with ex_result=150 -> EXMEMrd=3, EXMEM_result=150 at N+2; MEMWBrd=3, MEMWB_data=150 at N+3.
REQ-032 LW x3 (MemRead=1) then ADD x4,x3,x1 -> stall=1 for one cycle, bubble in ID/EX; then ADD issues; with mem_rdata=77, MEMWB_data=77.
REQ-033 LW x3 then ADD x4,x5,x6 -> stall stays 0.
REQ-034 Dependent ADD after LW x0 -> stall=0; ADD with rd=0, RegWrite=1 -> IDEX_RegWrite=0.
REQ-035 flush=1 together with load-use condition -> stall=0, one bubble; with STALL_COUNTER_EN, stall_count unchanged, while 3 real stalls give stall_count=3.
